// File: rtl/pll_drp_regs.sv
// DRP register file for the behavioural 7-series PLL: stores raw clock registers, decodes divide/duty/phase.
// Define PLL_DRP_READBACK_EN to return raw register contents on DRP reads (otherwise reads return 0).
module pll_drp_regs (
  input  logic        DCLK,
  input  logic        RST,
  input  logic        PWRDWN,
  input  logic [31:0] vco_period_1000,
  input  logic [6:0]  DADDR,
  input  logic        DEN,
  input  logic        DWE,
  input  logic [15:0] DI,
  output logic [15:0] DO,
  output logic        DRDY,
  output logic [31:0] CLKOUT0_DIVIDE,
  output logic [31:0] CLKOUT0_DUTY_CYCLE_1000,
  output logic [31:0] CLKOUT0_PHASE,
  output logic [31:0] CLKOUT1_DIVIDE,
  output logic [31:0] CLKOUT1_DUTY_CYCLE_1000,
  output logic [31:0] CLKOUT1_PHASE,
  output logic [31:0] CLKOUT2_DIVIDE,
  output logic [31:0] CLKOUT2_DUTY_CYCLE_1000,
  output logic [31:0] CLKOUT2_PHASE,
  output logic [31:0] CLKOUT3_DIVIDE,
  output logic [31:0] CLKOUT3_DUTY_CYCLE_1000,
  output logic [31:0] CLKOUT3_PHASE,
  output logic [31:0] CLKOUT4_DIVIDE,
  output logic [31:0] CLKOUT4_DUTY_CYCLE_1000,
  output logic [31:0] CLKOUT4_PHASE,
  output logic [31:0] CLKOUT5_DIVIDE,
  output logic [31:0] CLKOUT5_DUTY_CYCLE_1000,
  output logic [31:0] CLKOUT5_PHASE,
  output logic [31:0] CLKFBOUT_MULT,
  output logic [31:0] CLKFBOUT_PHASE,
  output logic [31:0] DIVCLK_DIVIDE
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;
  localparam int NGRP = 8;

  // Group index: 0..5 = CLKOUT0..5, 6 = CLKFBOUT, 7 = DIVCLK (single register).
  logic [0:0]  r_state;
  logic [15:0] r_reg1 [NGRP];
  logic [15:0] r_reg2 [NGRP];
  logic        r_vld  [NGRP];
  logic [15:0] r_do;
  logic [31:0] r_div  [NGRP];
  logic [31:0] r_duty [6];
  logic [31:0] r_ph   [7];

  logic        w_mapped;
  logic        w_sel2;
  logic [2:0]  w_grp;
  logic        w_accept;
  logic        w_wr;
  logic [15:0] w_rdata;
  logic [15:0] w_nreg1 [NGRP];
  logic [15:0] w_nreg2 [NGRP];
  logic        w_nvld  [NGRP];
  logic [31:0] w_d_div  [NGRP];
  logic [31:0] w_d_duty [6];
  logic [31:0] w_d_ph   [7];
  logic        w_unused;

  function automatic logic [31:0] f_cnt(input logic [5:0] f);
    return (f == 6'd0) ? 32'd64 : {26'd0, f};
  endfunction

  function automatic logic [31:0] f_divide(input logic [5:0] hi, input logic [5:0] lo,
                                           input logic nc);
    return nc ? 32'd1 : (f_cnt(hi) + f_cnt(lo));
  endfunction

  function automatic logic [31:0] f_duty(input logic [5:0] hi, input logic [5:0] lo,
                                         input logic nc, input logic e);
    logic [31:0] d;
    d = f_divide(hi, lo, nc);
    return nc ? 32'd500 : ((32'd1000 * ((32'd2 * f_cnt(hi)) + {31'd0, e})) / (32'd2 * d));
  endfunction

  function automatic logic [31:0] f_phase(input logic [5:0] dly, input logic [2:0] pm,
                                          input logic [5:0] hi, input logic [5:0] lo,
                                          input logic nc);
    logic [31:0] d;
    d = f_divide(hi, lo, nc);
    return ((({26'd0, dly} * 32'd8) + {29'd0, pm}) * 32'd360) / (32'd8 * d);
  endfunction

  always_comb begin
    w_mapped = 1'b1;
    w_sel2   = DADDR[0];
    w_grp    = 3'd0;
    case (DADDR)
      7'h06, 7'h07: w_grp = 3'd5;
      7'h08, 7'h09: w_grp = 3'd0;
      7'h0A, 7'h0B: w_grp = 3'd1;
      7'h0C, 7'h0D: w_grp = 3'd2;
      7'h0E, 7'h0F: w_grp = 3'd3;
      7'h10, 7'h11: w_grp = 3'd4;
      7'h14, 7'h15: w_grp = 3'd6;
      7'h16: begin
        w_grp  = 3'd7;
        w_sel2 = 1'b0;
      end
      default: w_mapped = 1'b0;
    endcase
  end

  assign w_accept = (r_state == S_IDLE) && DEN && !PWRDWN;
  assign w_wr     = w_accept && DWE && w_mapped;

  // Post-write register image, so decoded outputs land together with DRDY.
  always_comb begin
    w_nreg1 = r_reg1;
    w_nreg2 = r_reg2;
    w_nvld  = r_vld;
    if (w_wr) begin
      if (w_sel2) begin
        w_nreg2[w_grp] = DI;
      end else begin
        w_nreg1[w_grp] = DI;
        w_nvld[w_grp]  = 1'b1;
      end
    end
  end

  always_comb begin
    for (int g = 0; g < 7; g++) begin
      w_d_div[g] = f_divide(w_nreg1[g][11:6], w_nreg1[g][5:0], w_nreg2[g][6]);
      w_d_ph[g]  = f_phase(w_nreg2[g][5:0], w_nreg1[g][15:13], w_nreg1[g][11:6],
                           w_nreg1[g][5:0], w_nreg2[g][6]);
    end
    for (int g = 0; g < 6; g++) begin
      w_d_duty[g] = f_duty(w_nreg1[g][11:6], w_nreg1[g][5:0], w_nreg2[g][6], w_nreg2[g][7]);
    end
    w_d_div[7] = f_divide(w_nreg1[7][11:6], w_nreg1[7][5:0], w_nreg1[7][12]);
  end

`ifdef PLL_DRP_READBACK_EN
  always_comb begin
    w_rdata = 16'h0000;
    if (!DWE && w_mapped) begin
      w_rdata = w_sel2 ? r_reg2[w_grp] : r_reg1[w_grp];
    end
  end
`else
  assign w_rdata = 16'h0000;
`endif

  // Reserved bits and the informational VCO period do not feed any decode.
  always_comb begin
    w_unused = ^vco_period_1000;
    for (int g = 0; g < NGRP; g++) begin
      w_unused = w_unused ^ (^w_nreg1[g]) ^ (^w_nreg2[g]);
    end
  end

  always_ff @(posedge DCLK) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_do    <= 16'h0000;
      for (int g = 0; g < NGRP; g++) begin
        r_reg1[g] <= 16'h0000;
        r_reg2[g] <= 16'h0000;
        r_vld[g]  <= 1'b0;
        r_div[g]  <= 32'd0;
      end
      for (int g = 0; g < 6; g++) r_duty[g] <= 32'd0;
      for (int g = 0; g < 7; g++) r_ph[g] <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state <= S_BUSY;
            r_do    <= DWE ? 16'h0000 : w_rdata;
            r_reg1  <= w_nreg1;
            r_reg2  <= w_nreg2;
            r_vld   <= w_nvld;
            for (int g = 0; g < NGRP; g++) r_div[g] <= w_nvld[g] ? w_d_div[g] : 32'd0;
            for (int g = 0; g < 6; g++) r_duty[g] <= w_nvld[g] ? w_d_duty[g] : 32'd0;
            for (int g = 0; g < 7; g++) r_ph[g] <= w_nvld[g] ? w_d_ph[g] : 32'd0;
          end
        end
        S_BUSY: begin
          r_state <= S_IDLE;
          r_do    <= 16'h0000;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // A reset arriving during BUSY suppresses the completion that edge would have seen.
  assign DRDY = (r_state == S_BUSY) && !RST;
  assign DO   = RST ? 16'h0000 : r_do;

  assign CLKOUT0_DIVIDE          = r_div[0];
  assign CLKOUT0_DUTY_CYCLE_1000 = r_duty[0];
  assign CLKOUT0_PHASE           = r_ph[0];
  assign CLKOUT1_DIVIDE          = r_div[1];
  assign CLKOUT1_DUTY_CYCLE_1000 = r_duty[1];
  assign CLKOUT1_PHASE           = r_ph[1];
  assign CLKOUT2_DIVIDE          = r_div[2];
  assign CLKOUT2_DUTY_CYCLE_1000 = r_duty[2];
  assign CLKOUT2_PHASE           = r_ph[2];
  assign CLKOUT3_DIVIDE          = r_div[3];
  assign CLKOUT3_DUTY_CYCLE_1000 = r_duty[3];
  assign CLKOUT3_PHASE           = r_ph[3];
  assign CLKOUT4_DIVIDE          = r_div[4];
  assign CLKOUT4_DUTY_CYCLE_1000 = r_duty[4];
  assign CLKOUT4_PHASE           = r_ph[4];
  assign CLKOUT5_DIVIDE          = r_div[5];
  assign CLKOUT5_DUTY_CYCLE_1000 = r_duty[5];
  assign CLKOUT5_PHASE           = r_ph[5];
  assign CLKFBOUT_MULT           = r_div[6];
  assign CLKFBOUT_PHASE          = r_ph[6];
  assign DIVCLK_DIVIDE           = r_div[7];

endmodule

// File: tb/tb_pll_drp_regs.sv
// Bench for pll_drp_regs: directed plan cases plus random DRP traffic against an address-map model.
module tb_pll_drp_regs;

  logic        DCLK = 1'b0;
  logic        RST = 1'b1;
  logic        PWRDWN = 1'b0;
  logic [31:0] vco_period_1000 = 32'd1000;
  logic [6:0]  DADDR = 7'd0;
  logic        DEN = 1'b0;
  logic        DWE = 1'b0;
  logic [15:0] DI = 16'd0;
  wire  [15:0] DO;
  wire         DRDY;
  wire  [31:0] o_div  [8];
  wire  [31:0] o_duty [6];
  wire  [31:0] o_ph   [7];

  int n_cmp = 0;
  int n_fail = 0;

  logic [15:0] m_mem [128];
  bit          m_vld [8];

  always #5 DCLK = ~DCLK;

  pll_drp_regs dut (
    .DCLK(DCLK), .RST(RST), .PWRDWN(PWRDWN), .vco_period_1000(vco_period_1000),
    .DADDR(DADDR), .DEN(DEN), .DWE(DWE), .DI(DI), .DO(DO), .DRDY(DRDY),
    .CLKOUT0_DIVIDE(o_div[0]), .CLKOUT0_DUTY_CYCLE_1000(o_duty[0]), .CLKOUT0_PHASE(o_ph[0]),
    .CLKOUT1_DIVIDE(o_div[1]), .CLKOUT1_DUTY_CYCLE_1000(o_duty[1]), .CLKOUT1_PHASE(o_ph[1]),
    .CLKOUT2_DIVIDE(o_div[2]), .CLKOUT2_DUTY_CYCLE_1000(o_duty[2]), .CLKOUT2_PHASE(o_ph[2]),
    .CLKOUT3_DIVIDE(o_div[3]), .CLKOUT3_DUTY_CYCLE_1000(o_duty[3]), .CLKOUT3_PHASE(o_ph[3]),
    .CLKOUT4_DIVIDE(o_div[4]), .CLKOUT4_DUTY_CYCLE_1000(o_duty[4]), .CLKOUT4_PHASE(o_ph[4]),
    .CLKOUT5_DIVIDE(o_div[5]), .CLKOUT5_DUTY_CYCLE_1000(o_duty[5]), .CLKOUT5_PHASE(o_ph[5]),
    .CLKFBOUT_MULT(o_div[6]), .CLKFBOUT_PHASE(o_ph[6]), .DIVCLK_DIVIDE(o_div[7])
  );

  // ---------------- reference model ----------------
  function automatic logic [6:0] reg1_addr(input int g);
    case (g)
      5:       return 7'h06;
      6:       return 7'h14;
      7:       return 7'h16;
      default: return 7'(8 + 2 * g);
    endcase
  endfunction

  function automatic bit is_mapped(input logic [6:0] a);
    return (a >= 7'h06 && a <= 7'h11) || (a >= 7'h14 && a <= 7'h16);
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < 128; i++) m_mem[i] = 16'h0;
    for (int g = 0; g < 8; g++) m_vld[g] = 1'b0;
  endfunction

  function automatic void m_write(input logic [6:0] a, input logic [15:0] d);
    if (is_mapped(a)) begin
      m_mem[a] = d;
      for (int g = 0; g < 8; g++) if (reg1_addr(g) == a) m_vld[g] = 1'b1;
    end
  endfunction

  function automatic int unsigned cnt(input int unsigned f);
    return (f == 0) ? 64 : f;
  endfunction

  function automatic int unsigned e_div(input int g);
    int unsigned r1, r2, nc;
    if (!m_vld[g]) return 0;
    r1 = m_mem[reg1_addr(g)];
    r2 = m_mem[reg1_addr(g) + 7'd1];
    nc = (g == 7) ? ((r1 >> 12) & 1) : ((r2 >> 6) & 1);
    return (nc != 0) ? 1 : cnt((r1 >> 6) & 63) + cnt(r1 & 63);
  endfunction

  function automatic int unsigned e_duty(input int g);
    int unsigned r1, r2, hi;
    if (!m_vld[g]) return 0;
    r1 = m_mem[reg1_addr(g)];
    r2 = m_mem[reg1_addr(g) + 7'd1];
    if (((r2 >> 6) & 1) != 0) return 500;
    hi = cnt((r1 >> 6) & 63);
    return (1000 * (2 * hi + ((r2 >> 7) & 1))) / (2 * e_div(g));
  endfunction

  function automatic int unsigned e_ph(input int g);
    int unsigned r1, r2;
    if (!m_vld[g]) return 0;
    r1 = m_mem[reg1_addr(g)];
    r2 = m_mem[reg1_addr(g) + 7'd1];
    return (((r2 & 63) * 8 + (r1 >> 13)) * 360) / (8 * e_div(g));
  endfunction

  function automatic logic [15:0] e_do(input logic [6:0] a, input logic we);
    logic [15:0] v;
    v = (!we && is_mapped(a)) ? m_mem[a] : 16'h0;
`ifdef PLL_DRP_READBACK_EN
    return v;
`else
    return v & 16'h0000;
`endif
  endfunction

  // One DRP transaction; returns DRDY/DO sampled in the cycle after DEN was taken.
  task automatic txn(input logic [6:0] a, input logic we, input logic [15:0] d,
                     output logic rdy, output logic [15:0] rdo);
    @(negedge DCLK);
    DADDR = a; DWE = we; DI = d; DEN = 1'b1;
    @(negedge DCLK);
    DEN = 1'b0;
    rdy = DRDY;
    rdo = DO;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    RST = 1'b1;
    repeat (3) @(negedge DCLK);
    n_cmp++; if (DRDY !== 1'b0) begin n_fail++; $display("FAIL reset_drdy got %b want 0", DRDY); end
    n_cmp++; if (DO !== 16'h0) begin n_fail++; $display("FAIL reset_do got %h want 0000", DO); end
    for (int g = 0; g < 8; g++) begin
      n_cmp++;
      if (o_div[g] !== 32'd0) begin n_fail++; $display("FAIL reset_div[%0d] got %0d want 0", g, o_div[g]); end
    end
    RST = 1'b0;
    m_reset();
  endtask

  task automatic test_plan_decode();
    logic rdy; logic [15:0] rdo;
    txn(7'h08, 1'b1, 16'h0041, rdy, rdo); m_write(7'h08, 16'h0041);
    n_cmp++; if (rdy !== 1'b1) begin n_fail++; $display("FAIL plan1_drdy got %b want 1", rdy); end
    n_cmp++; if (o_div[0] !== 32'd2) begin n_fail++; $display("FAIL plan1_div got %0d want 2", o_div[0]); end
    n_cmp++; if (o_duty[0] !== 32'd500) begin n_fail++; $display("FAIL plan1_duty got %0d want 500", o_duty[0]); end
    n_cmp++; if (o_ph[0] !== 32'd0) begin n_fail++; $display("FAIL plan1_phase got %0d want 0", o_ph[0]); end
    for (int g = 1; g < 8; g++) begin
      n_cmp++;
      if (o_div[g] !== 32'd0) begin n_fail++; $display("FAIL plan1_other_div[%0d] got %0d want 0", g, o_div[g]); end
    end
    @(negedge DCLK);
    n_cmp++; if (DRDY !== 1'b0) begin n_fail++; $display("FAIL plan1_drdy_width got %b want 0", DRDY); end

    txn(7'h08, 1'b1, 16'h8083, rdy, rdo); m_write(7'h08, 16'h8083);
    n_cmp++; if (o_div[0] !== 32'd5) begin n_fail++; $display("FAIL plan2_div got %0d want 5", o_div[0]); end
    n_cmp++; if (o_duty[0] !== 32'd400) begin n_fail++; $display("FAIL plan2_duty got %0d want 400", o_duty[0]); end
    n_cmp++; if (o_ph[0] !== 32'd36) begin n_fail++; $display("FAIL plan2_phase got %0d want 36", o_ph[0]); end
    txn(7'h09, 1'b1, 16'h0080, rdy, rdo); m_write(7'h09, 16'h0080);
    n_cmp++; if (o_duty[0] !== 32'd500) begin n_fail++; $display("FAIL plan3_duty got %0d want 500", o_duty[0]); end
    n_cmp++; if (o_ph[0] !== 32'd36) begin n_fail++; $display("FAIL plan3_phase got %0d want 36", o_ph[0]); end
    n_cmp++; if (o_div[0] !== 32'd5) begin n_fail++; $display("FAIL plan3_div got %0d want 5", o_div[0]); end

    txn(7'h16, 1'b1, 16'h1000, rdy, rdo); m_write(7'h16, 16'h1000);
    n_cmp++; if (o_div[7] !== 32'd1) begin n_fail++; $display("FAIL plan_divclk got %0d want 1", o_div[7]); end
    txn(7'h14, 1'b1, 16'h0145, rdy, rdo); m_write(7'h14, 16'h0145);
    n_cmp++; if (o_div[6] !== 32'd10) begin n_fail++; $display("FAIL plan_fbmult got %0d want 10", o_div[6]); end
  endtask

  task automatic test_readback();
    logic rdy; logic [15:0] rdo; logic [15:0] want;
`ifdef PLL_DRP_READBACK_EN
    want = 16'h8083;
`else
    want = 16'h0000;
`endif
    txn(7'h08, 1'b0, 16'h0, rdy, rdo);
    n_cmp++; if (rdo !== want) begin n_fail++; $display("FAIL rb_08 got %h want %h", rdo, want); end
    txn(7'h00, 1'b0, 16'h0, rdy, rdo);
    n_cmp++; if (rdo !== 16'h0) begin n_fail++; $display("FAIL rb_00 got %h want 0000", rdo); end
    txn(7'h00, 1'b1, 16'(($urandom % 65535) + 1), rdy, rdo);
    n_cmp++; if (rdy !== 1'b1) begin n_fail++; $display("FAIL unmapped_wr_drdy got %b want 1", rdy); end
    for (int g = 0; g < 8; g++) begin
      n_cmp++;
      if (o_div[g] !== e_div(g)) begin n_fail++; $display("FAIL unmapped_wr_div[%0d] got %0d want %0d", g, o_div[g], e_div(g)); end
    end
    txn(7'h00, 1'b0, 16'h0, rdy, rdo);
    n_cmp++; if (rdo !== 16'h0) begin n_fail++; $display("FAIL unmapped_rd_after_wr got %h want 0000", rdo); end
  endtask

  task automatic test_busy_den();
    logic [15:0] a_dat, b_dat;
    a_dat = 16'($urandom); b_dat = 16'($urandom);
    @(negedge DCLK);
    DADDR = 7'h0A; DWE = 1'b1; DI = a_dat; DEN = 1'b1;
    @(negedge DCLK);
    n_cmp++; if (DRDY !== 1'b1) begin n_fail++; $display("FAIL busy_first_drdy got %b want 1", DRDY); end
    DADDR = 7'h0C; DI = b_dat;
    m_write(7'h0A, a_dat);
    @(negedge DCLK);
    DEN = 1'b0;
    n_cmp++; if (DRDY !== 1'b0) begin n_fail++; $display("FAIL busy_second_drdy got %b want 0", DRDY); end
    for (int g = 0; g < 8; g++) begin
      n_cmp++;
      if (o_div[g] !== e_div(g)) begin n_fail++; $display("FAIL busy_div[%0d] got %0d want %0d", g, o_div[g], e_div(g)); end
      if (g < 7) begin
        n_cmp++;
        if (o_ph[g] !== e_ph(g)) begin n_fail++; $display("FAIL busy_ph[%0d] got %0d want %0d", g, o_ph[g], e_ph(g)); end
      end
    end
  endtask

  task automatic test_pwrdwn();
    logic rdy; logic [15:0] rdo;
    @(negedge DCLK);
    PWRDWN = 1'b1; DADDR = 7'h0E; DWE = 1'b1; DI = 16'($urandom) | 16'h0041; DEN = 1'b1;
    @(negedge DCLK);
    DEN = 1'b0;
    n_cmp++; if (DRDY !== 1'b0) begin n_fail++; $display("FAIL pwrdwn_drdy1 got %b want 0", DRDY); end
    @(negedge DCLK);
    n_cmp++; if (DRDY !== 1'b0) begin n_fail++; $display("FAIL pwrdwn_drdy2 got %b want 0", DRDY); end
    n_cmp++; if (o_div[3] !== e_div(3)) begin n_fail++; $display("FAIL pwrdwn_div3 got %0d want %0d", o_div[3], e_div(3)); end
    PWRDWN = 1'b0;
    txn(7'h0E, 1'b0, 16'h0, rdy, rdo);
    n_cmp++; if (rdo !== e_do(7'h0E, 1'b0)) begin n_fail++; $display("FAIL pwrdwn_held got %h want %h", rdo, e_do(7'h0E, 1'b0)); end
  endtask

  task automatic test_rst_abort();
    @(negedge DCLK);
    DADDR = 7'h10; DWE = 1'b1; DI = 16'($urandom); DEN = 1'b1;
    @(negedge DCLK);
    DEN = 1'b0; RST = 1'b1;
    #1;
    n_cmp++; if (DRDY !== 1'b0) begin n_fail++; $display("FAIL rst_abort_drdy got %b want 0", DRDY); end
    @(negedge DCLK);
    RST = 1'b0;
    m_reset();
    n_cmp++; if (DRDY !== 1'b0) begin n_fail++; $display("FAIL rst_after_drdy got %b want 0", DRDY); end
    n_cmp++; if (DO !== 16'h0) begin n_fail++; $display("FAIL rst_after_do got %h want 0000", DO); end
    for (int g = 0; g < 8; g++) begin
      n_cmp++;
      if (o_div[g] !== 32'd0) begin n_fail++; $display("FAIL rst_after_div[%0d] got %0d want 0", g, o_div[g]); end
      if (g < 7) begin
        n_cmp++;
        if (o_ph[g] !== 32'd0) begin n_fail++; $display("FAIL rst_after_ph[%0d] got %0d want 0", g, o_ph[g]); end
      end
    end
  endtask

  task automatic test_random();
    logic rdy; logic [15:0] rdo; logic [6:0] a; logic we; logic [15:0] d; logic [15:0] want_do;
    int idx;
    for (int t = 0; t < 300; t++) begin
      if ($urandom_range(0, 4) == 0) a = 7'($urandom_range(0, 127));
      else begin
        idx = $urandom_range(0, 14);
        a = (idx < 12) ? 7'(6 + idx) : 7'(20 + idx - 12);
      end
      we = ($urandom_range(0, 2) != 0);
      d = 16'($urandom);
      want_do = e_do(a, we);
      txn(a, we, d, rdy, rdo);
      if (we) m_write(a, d);
      n_cmp++; if (rdy !== 1'b1) begin n_fail++; $display("FAIL rnd%0d_drdy got %b want 1", t, rdy); end
      n_cmp++; if (rdo !== want_do) begin n_fail++; $display("FAIL rnd%0d_do addr %h got %h want %h", t, a, rdo, want_do); end
      for (int g = 0; g < 8; g++) begin
        n_cmp++;
        if (o_div[g] !== e_div(g)) begin n_fail++; $display("FAIL rnd%0d_div[%0d] got %0d want %0d", t, g, o_div[g], e_div(g)); end
        if (g < 6) begin
          n_cmp++;
          if (o_duty[g] !== e_duty(g)) begin n_fail++; $display("FAIL rnd%0d_duty[%0d] got %0d want %0d", t, g, o_duty[g], e_duty(g)); end
        end
        if (g < 7) begin
          n_cmp++;
          if (o_ph[g] !== e_ph(g)) begin n_fail++; $display("FAIL rnd%0d_ph[%0d] got %0d want %0d", t, g, o_ph[g], e_ph(g)); end
        end
      end
    end
  endtask

  initial begin
    m_reset();
    test_reset();
    test_plan_decode();
    test_readback();
    test_busy_den();
    test_pwrdwn();
    test_rst_abort();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
